// File: rtl/nanov_exec_harness_pkg.sv
// Shared definitions for the nanoV execution harness: idle instruction
// encoding, FSM state type and the phase-counter width helper.
package nanov_exec_harness_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic int unsigned cyc_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/nanov_exec_harness_fifo.sv
// Generic synchronous FIFO with synchronous clear; used for both the
// instruction queue and the result queue of the execution harness.
module nanov_exec_harness_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A push on a full queue is still taken when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/nanov_exec_harness.sv
// Streams queued instructions into the nanoV core one at a time, sequences the
// per-instruction phase counter and collects results into a valid/ready queue.
module nanov_exec_harness
  import nanov_exec_harness_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     CYCLES   = 4,
  parameter int unsigned     IQ_DEPTH = 4,
  parameter int unsigned     RQ_DEPTH = 2,
  parameter logic [ILEN-1:0] NOP      = ILEN'(NOP_INSTR)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [ILEN-1:0]               in_instr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [ILEN-1:0]               core_instr,
  output logic [cyc_width(CYCLES)-1:0]  core_cycle,
  input  logic [XLEN-1:0]               core_data,
  input  logic                          core_br,
  output logic [XLEN-1:0]               res_data,
  output logic                          res_branch,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          busy,
  output logic [15:0]                   retired
);

  localparam int unsigned CYC_W = cyc_width(CYCLES);
  localparam int unsigned IQ_CW = $clog2(IQ_DEPTH) + 1;
  localparam int unsigned RQ_CW = $clog2(RQ_DEPTH) + 1;

  state_t            state, state_n;
  logic [ILEN-1:0]   instr_n;
  logic [CYC_W-1:0]  cycle_n;
  logic              launch;
  logic              launch_ok;
  logic              final_phase;

  logic              iq_push, iq_full, iq_empty;
  logic [ILEN-1:0]   iq_head;
  logic [IQ_CW-1:0]  iq_count;

  logic              rq_push, rq_pop, rq_full, rq_empty;
  logic [XLEN:0]     rq_head;
  logic [RQ_CW-1:0]  rq_count;
  logic [RQ_CW:0]    rq_occ;

  assign in_ready = ~iq_full & ~flush;
  assign iq_push  = in_valid & in_ready;

  nanov_exec_harness_fifo #(
    .WIDTH (ILEN),
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk   (clk),
    .rstn  (rstn),
    .clear (flush),
    .push  (iq_push),
    .pop   (launch),
    .wdata (in_instr),
    .rdata (iq_head),
    .full  (iq_full),
    .empty (iq_empty),
    .count (iq_count)
  );

  nanov_exec_harness_fifo #(
    .WIDTH (XLEN + 1),
    .DEPTH (RQ_DEPTH)
  ) u_rq (
    .clk   (clk),
    .rstn  (rstn),
    .clear (1'b0),
    .push  (rq_push),
    .pop   (rq_pop),
    .wdata ({core_br, core_data}),
    .rdata (rq_head),
    .full  (rq_full),
    .empty (rq_empty),
    .count (rq_count)
  );

  assign res_valid  = ~rq_empty;
  assign res_data   = rq_head[XLEN-1:0];
  assign res_branch = rq_head[XLEN];
  assign rq_pop     = res_valid & res_ready;

  assign final_phase = (state == ST_EXEC) && (core_cycle == CYC_W'(CYCLES - 1));
  assign rq_push     = final_phase;

  // Occupancy after this clock includes the result retiring now, so a new
  // launch only happens once its own result slot is reserved.
  assign rq_occ    = {1'b0, rq_count} + (RQ_CW+1)'(rq_push) - (RQ_CW+1)'(rq_pop);
  assign launch_ok = ~iq_empty & ~flush & (rq_occ < (RQ_CW+1)'(RQ_DEPTH));

  assign busy = (state == ST_EXEC) | (iq_count != '0);

  always_comb begin
    state_n = state;
    instr_n = core_instr;
    cycle_n = core_cycle;
    launch  = 1'b0;
    case (state)
      ST_IDLE: launch = launch_ok;
      ST_EXEC: begin
        if (final_phase) launch = launch_ok;
        else             cycle_n = core_cycle + CYC_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase
    if (launch) begin
      state_n = ST_EXEC;
      instr_n = iq_head;
      cycle_n = '0;
    end else if (final_phase) begin
      state_n = ST_IDLE;
      instr_n = NOP;
      cycle_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      core_instr <= NOP;
      core_cycle <= '0;
      retired    <= '0;
    end else begin
      state      <= state_n;
      core_instr <= instr_n;
      core_cycle <= cycle_n;
      if (final_phase) retired <= retired + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && rq_push) assert (!rq_full || rq_pop);
  end

endmodule

// File: tb/tb_nanov_exec_harness.sv
// Directed bench for nanov_exec_harness; a tiny core model returns the
// I-type immediate as data and flags B-type opcodes as branches.
module tb_nanov_exec_harness;

  localparam logic [31:0] NOP_I  = 32'h0000_0013;
  localparam logic [31:0] ADDI5  = 32'h0050_0093;
  localparam logic [31:0] BEQ8   = 32'h0000_0463;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] core_instr;
  logic [1:0]  core_cycle;
  logic [31:0] core_data;
  logic        core_br;
  logic [31:0] res_data;
  logic        res_branch;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  int j;
  int n;

  always #5 clk = ~clk;

  assign core_data = {20'h0, core_instr[31:20]};
  assign core_br   = (core_instr[6:0] == 7'h63);

  nanov_exec_harness #(
    .XLEN     (32),
    .ILEN     (32),
    .CYCLES   (4),
    .IQ_DEPTH (4),
    .RQ_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_instr   (in_instr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .core_instr (core_instr),
    .core_cycle (core_cycle),
    .core_data  (core_data),
    .core_br    (core_br),
    .res_data   (res_data),
    .res_branch (res_branch),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .retired    (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_res(input string tag, input int max);
    int k = 0;
    while (res_valid !== 1'b1 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, res_valid}, 32'd1);
  endtask

  initial begin
    rstn = 1'b0; in_instr = '0; in_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_instr",  core_instr, NOP_I);
    chk("rst_cycle",  {30'd0, core_cycle}, 32'd0);
    chk("rst_inrdy",  {31'd0, in_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, res_valid}, 32'd0);
    chk("rst_rdata",  res_data, 32'd0);
    chk("rst_rbr",    {31'd0, res_branch}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_ret",    {16'd0, retired}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // single instruction
    in_instr = ADDI5; in_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("one_busy_q", {31'd0, busy}, 32'd1);
    chk("one_prelaunch", core_instr, NOP_I);
    @(negedge clk);
    chk("one_instr", core_instr, ADDI5);
    chk("one_cyc0", {30'd0, core_cycle}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("one_cyc", {30'd0, core_cycle}, 32'(i));
    end
    chk("one_novalid_yet", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    chk("one_valid", {31'd0, res_valid}, 32'd1);
    chk("one_data",  res_data, 32'd5);
    chk("one_br",    {31'd0, res_branch}, 32'd0);
    chk("one_ret",   {16'd0, retired}, 32'd1);
    chk("one_idle_instr", core_instr, NOP_I);
    chk("one_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("one_popped", {31'd0, res_valid}, 32'd0);

    // back-to-back, consumer always ready
    for (int k = 0; k < 19; k++) begin
      if (k < 4) begin
        in_valid = 1'b1;
        in_instr = 32'h0000_0093 | (32'(k + 1) << 20);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k == 5 || k == 9 || k == 13 || k == 17) begin
        chk("b2b_valid", {31'd0, res_valid}, 32'd1);
        chk("b2b_data", res_data, 32'((k - 1) / 4));
      end else begin
        chk("b2b_gap", {31'd0, res_valid}, 32'd0);
      end
    end
    chk("b2b_ret",  {16'd0, retired}, 32'd5);
    chk("b2b_busy", {31'd0, busy}, 32'd0);

    // backpressure: only two results may complete
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h0000_0093 | (32'(k + 5) << 20);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("bp_valid", {31'd0, res_valid}, 32'd1);
    chk("bp_head",  res_data, 32'd5);
    chk("bp_nop",   core_instr, NOP_I);
    chk("bp_cyc",   {30'd0, core_cycle}, 32'd0);
    chk("bp_busy",  {31'd0, busy}, 32'd1);
    chk("bp_ret",   {16'd0, retired}, 32'd7);
    res_ready = 1'b1;
    j = 0;
    for (int t = 0; t < 40; t++) begin
      if (res_valid === 1'b1 && j < 4) begin
        chk("bp_order", res_data, 32'(5 + j));
        j++;
      end
      @(negedge clk);
    end
    chk("bp_count", 32'(j), 32'd4);
    chk("bp_drained", {31'd0, res_valid}, 32'd0);
    chk("bp_ret2",  {16'd0, retired}, 32'd9);
    chk("bp_busy2", {31'd0, busy}, 32'd0);

    // fill RQ, then fill IQ, then flush during EXEC
    res_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h0000_0093 | (32'(k + 9) << 20);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("ff_ret", {16'd0, retired}, 32'd11);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h0000_0093 | (32'(k + 17) << 20);
      @(negedge clk);
      chk("ff_inrdy", {31'd0, in_ready}, (k < 3) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    chk("ff_nop",  core_instr, NOP_I);
    chk("ff_busy", {31'd0, busy}, 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("ff_launch", core_instr, 32'h0110_0093);
    chk("ff_cyc0",   {30'd0, core_cycle}, 32'd0);
    chk("ff_head",   res_data, 32'd10);
    flush = 1'b1;
    #1;
    chk("ff_flush_inrdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("ff_exec_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    chk("ff_done_busy", {31'd0, busy}, 32'd0);
    chk("ff_done_nop",  core_instr, NOP_I);
    chk("ff_done_ret",  {16'd0, retired}, 32'd12);
    chk("ff_inrdy2",    {31'd0, in_ready}, 32'd1);
    chk("ff_rq_head",   res_data, 32'd10);
    res_ready = 1'b1;
    @(negedge clk);
    chk("ff_inflight_valid", {31'd0, res_valid}, 32'd1);
    chk("ff_inflight_data",  res_data, 32'h11);
    @(negedge clk);
    chk("ff_rq_empty", {31'd0, res_valid}, 32'd0);

    // branch capture
    in_instr = BEQ8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_res("br_timeout", 12);
    chk("br_flag", {31'd0, res_branch}, 32'd1);
    chk("br_data", res_data, 32'd0);
    chk("br_ret",  {16'd0, retired}, 32'd13);
    @(negedge clk);

    // retired counter wrap
    force dut.retired = 16'hFFFF;
    @(negedge clk);
    release dut.retired;
    @(negedge clk);
    chk("wrap_pre", {16'd0, retired}, 32'h0000_FFFF);
    in_instr = ADDI5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_res("wrap_timeout", 12);
    chk("wrap_ret",  {16'd0, retired}, 32'd0);
    chk("wrap_data", res_data, 32'd5);
    @(negedge clk);

    // reset mid-instruction
    in_instr = ADDI5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (core_cycle !== 2'd2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_cyc2", {30'd0, core_cycle}, 32'd2);
    rstn = 1'b0;
    #1;
    chk("mid_instr",  core_instr, NOP_I);
    chk("mid_cyc",    {30'd0, core_cycle}, 32'd0);
    chk("mid_rvalid", {31'd0, res_valid}, 32'd0);
    chk("mid_ret",    {16'd0, retired}, 32'd0);
    chk("mid_busy",   {31'd0, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_noresult", {31'd0, res_valid}, 32'd0);
    chk("mid_ret2",     {16'd0, retired}, 32'd0);
    chk("mid_idle",     {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
